// File: rtl/hash_round_sequencer.sv
// hash_round_sequencer
// Sequences the two compression passes of a double-hash nonce search.
// For every nonce in [nonce_base, nonce_limit] (stepping by NONCE_STEP) the
// block runs 64 midstate rounds (en1), 64 double-hash rounds (en2) and one
// CHECK cycle where the downstream comparator reports hit.
//
// Ports
//   clk          single clock, all state on its rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a search (sampled in IDLE only)
//   abort        cancel the search from any state, highest priority
//   nonce_base   first nonce of the inclusive range, captured on start
//   nonce_limit  last nonce of the inclusive range, captured on start
//   early_stop   pass-2 partial-digest reject; ends the attempt as a miss
//   hit          final digest meets target; looked at in CHECK only
//   r_cntr       round index for scheduler/compressor
//   en1, en2     pass-1 / pass-2 compressor enables
//   first_rnd    round 0 of either pass (IV / working-register load)
//   nonce        nonce under test
//   busy         any state except IDLE
//   done         one-cycle completion pulse
//   found        a hit was seen in the last completed search
//   found_nonce  the nonce that produced the hit
module hash_round_sequencer #(
    parameter logic [31:0] NONCE_STEP = 32'd1,
    parameter logic [3:0]  CORE       = 4'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] nonce_base,
    input  logic [31:0] nonce_limit,
    input  logic        early_stop,
    input  logic        hit,
    output logic [5:0]  r_cntr,
    output logic        en1,
    output logic        en2,
    output logic        first_rnd,
    output logic [31:0] nonce,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PASS1  = 3'd1,
        PASS2  = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [5:0] ROUND_LAST = 6'd63;

    // Core index is carried only so it is visible in netlists for debug.
    logic [3:0] core_unused;
    assign core_unused = CORE;

    state_t      state_reg, state_next;
    logic [5:0]  r_cntr_reg, r_cntr_next;
    logic [31:0] nonce_reg, nonce_next;
    logic [31:0] limit_reg, limit_next;
    logic        found_reg, found_next;
    logic [31:0] found_nonce_reg, found_nonce_next;
    logic        en1_reg, en1_next;
    logic        en2_reg, en2_next;
    logic        first_rnd_reg, first_rnd_next;
    logic        done_reg, done_next;
    logic        busy_reg, busy_next;
    logic        advance;
    logic        last_attempt;

    // Comparing the remaining distance instead of computing nonce+step keeps
    // the exhaustion test correct right up to 32'hFFFFFFFF (no wrap to 0).
    assign last_attempt = (limit_reg - nonce_reg) < NONCE_STEP;

    always_comb begin
        state_next       = state_reg;
        r_cntr_next      = r_cntr_reg;
        nonce_next       = nonce_reg;
        limit_next       = limit_reg;
        found_next       = found_reg;
        found_nonce_next = found_nonce_reg;
        advance          = 1'b0;

        if (abort) begin
            state_next       = IDLE;
            r_cntr_next      = '0;
            found_next       = 1'b0;
            found_nonce_next = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        found_next       = 1'b0;
                        found_nonce_next = '0;
                        r_cntr_next      = '0;
                        if (nonce_base > nonce_limit) begin
                            state_next = FINISH;
                        end else begin
                            state_next = PASS1;
                            nonce_next = nonce_base;
                            limit_next = nonce_limit;
                        end
                    end
                end
                PASS1: begin
                    if (r_cntr_reg == ROUND_LAST) begin
                        state_next  = PASS2;
                        r_cntr_next = '0;
                    end else begin
                        r_cntr_next = r_cntr_reg + 6'd1;
                    end
                end
                PASS2: begin
                    // A partial-digest reject skips CHECK entirely.
                    if (early_stop) begin
                        advance = 1'b1;
                    end else if (r_cntr_reg == ROUND_LAST) begin
                        state_next  = CHECK;
                        r_cntr_next = '0;
                    end else begin
                        r_cntr_next = r_cntr_reg + 6'd1;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        found_next       = 1'b1;
                        found_nonce_next = nonce_reg;
                        state_next       = FINISH;
                    end else begin
                        advance = 1'b1;
                    end
                end
                FINISH: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next  = IDLE;
                    r_cntr_next = '0;
                end
            endcase

            if (advance) begin
                r_cntr_next = '0;
                if (last_attempt) begin
                    state_next = FINISH;
                end else begin
                    state_next = PASS1;
                    nonce_next = nonce_reg + NONCE_STEP;
                end
            end
        end

        // Enables and pulses are decoded from the next state and registered,
        // so the compressor sees clean flop outputs.
        en1_next       = (state_next == PASS1);
        en2_next       = (state_next == PASS2);
        first_rnd_next = ((state_next == PASS1) || (state_next == PASS2))
                         && (r_cntr_next == 6'd0);
        done_next      = (state_next == FINISH);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            r_cntr_reg      <= '0;
            nonce_reg       <= '0;
            limit_reg       <= '0;
            found_reg       <= 1'b0;
            found_nonce_reg <= '0;
            en1_reg         <= 1'b0;
            en2_reg         <= 1'b0;
            first_rnd_reg   <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            r_cntr_reg      <= r_cntr_next;
            nonce_reg       <= nonce_next;
            limit_reg       <= limit_next;
            found_reg       <= found_next;
            found_nonce_reg <= found_nonce_next;
            en1_reg         <= en1_next;
            en2_reg         <= en2_next;
            first_rnd_reg   <= first_rnd_next;
            done_reg        <= done_next;
            busy_reg        <= busy_next;
        end
    end

    assign r_cntr      = r_cntr_reg;
    assign en1         = en1_reg;
    assign en2         = en2_reg;
    assign first_rnd   = first_rnd_reg;
    assign nonce       = nonce_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign found       = found_reg;
    assign found_nonce = found_nonce_reg;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Testbench for hash_round_sequencer: directed scenarios with hand-computed
// expectations plus a long randomized run, all checked every cycle against
// an attempt-level behavioural model.
module tb_hash_round_sequencer;

    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        early_stop = 1'b0;
    logic        hit = 1'b0;
    logic [31:0] nonce_base = '0;
    logic [31:0] nonce_limit = '0;
    logic [5:0]  r_cntr;
    logic        en1, en2, first_rnd, busy, done, found;
    logic [31:0] nonce, found_nonce;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] seen[$];

    hash_round_sequencer #(.NONCE_STEP(STEP), .CORE(4'd2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .nonce_base(nonce_base), .nonce_limit(nonce_limit),
        .early_stop(early_stop), .hit(hit), .r_cntr(r_cntr),
        .en1(en1), .en2(en2), .first_rnd(first_rnd), .nonce(nonce),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph 0 = idle, 1 = searching, 2 = completion cycle.
    // k is the cycle index inside the current attempt: 0..63 pass 1,
    // 64..127 pass 2, 128 the check cycle.
    typedef struct packed {
        logic [1:0]  ph;
        logic [7:0]  k;
        logic [31:0] n;
        logic [31:0] lim;
        logic [31:0] fn;
        logic        f;
    } model_t;

    model_t m = '0;

    function automatic model_t model_step(input model_t cur, input logic st, input logic ab,
                                          input logic es, input logic h,
                                          input logic [31:0] b, input logic [31:0] l);
        model_t r;
        bit adv;
        r = cur;
        adv = 1'b0;
        if (ab) begin
            r.ph = 2'd0; r.k = 8'd0; r.f = 1'b0; r.fn = '0;
            return r;
        end
        case (cur.ph)
            2'd0: if (st) begin
                r.f = 1'b0; r.fn = '0; r.k = 8'd0;
                if (b > l) r.ph = 2'd2;
                else begin r.ph = 2'd1; r.n = b; r.lim = l; end
            end
            2'd1: begin
                if (cur.k >= 8'd64 && cur.k < 8'd128 && es) adv = 1'b1;
                else if (cur.k == 8'd128) begin
                    if (h) begin r.f = 1'b1; r.fn = cur.n; r.ph = 2'd2; end
                    else adv = 1'b1;
                end else r.k = cur.k + 8'd1;
            end
            default: r.ph = 2'd0;
        endcase
        if (adv) begin
            r.k = 8'd0;
            if (({1'b0, cur.n} + {1'b0, STEP}) > {1'b0, cur.lim}) r.ph = 2'd2;
            else r.n = cur.n + STEP;
        end
        return r;
    endfunction

    function automatic logic [11:0] model_out(input model_t cur);
        logic in_hash;
        logic [5:0] rc;
        in_hash = (cur.ph == 2'd1) && (cur.k < 8'd128);
        rc = in_hash ? 6'(cur.k % 8'd64) : 6'd0;
        return {cur.ph != 2'd0, in_hash && cur.k < 8'd64, in_hash && cur.k >= 8'd64,
                in_hash && (cur.k % 8'd64) == 8'd0, cur.ph == 2'd2, cur.f, rc};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_step(m, start, abort, early_stop, hit, nonce_base, nonce_limit);
    end

    always @(negedge clk) begin
        check("ctl", 64'({busy, en1, en2, first_rnd, done, found, r_cntr}), 64'(model_out(m)));
        if (m.ph == 2'd1) check("nonce", 64'(nonce), 64'(m.n));
        if (m.f) check("found_nonce", 64'(found_nonce), 64'(m.fn));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input logic [31:0] b, input logic [31:0] l, input logic h,
                              input logic es60, output int edges, output int n1, output int n2);
        nonce_base = b; nonce_limit = l; hit = h; start = 1'b1;
        tick();
        start = 1'b0;
        seen.delete();
        edges = 0; n1 = 0; n2 = 0;
        for (int i = 1; i <= 2000; i++) begin
            if (en1) n1++;
            if (en2) n2++;
            if (en1 && first_rnd) seen.push_back(nonce);
            if (done) begin edges = i; break; end
            early_stop = es60 && en2 && (r_cntr == 6'd60);
            tick();
        end
        early_stop = 1'b0; hit = 1'b0;
        if (edges == 0) check("search_timeout", 64'd0, 64'd1);
    endtask

    int edges, n1, n2;
    logic [31:0] exp_n[3];
    bit seen_done;

    initial begin
        repeat (2) tick();
        check("reset_ctl", 64'({busy, en1, en2, first_rnd, done, found, r_cntr}), 64'd0);
        check("reset_nonce", 64'({nonce, found_nonce}), 64'd0);
        rst_n = 1'b1;
        tick();

        // abort beats start in IDLE
        nonce_base = 32'd1; nonce_limit = 32'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 64'(busy), 64'd0);
        tick();

        // single nonce, hit
        run_search(32'd5, 32'd5, 1'b1, 1'b0, edges, n1, n2);
        check("hit_edges", 64'(edges), 64'd130);
        check("hit_en1", 64'(n1), 64'd64);
        check("hit_en2", 64'(n2), 64'd64);
        check("hit_found", 64'(found), 64'd1);
        check("hit_found_nonce", 64'(found_nonce), 64'd5);
        repeat (3) tick();
        check("found_hold", 64'({found, found_nonce}), 64'({1'b1, 32'd5}));

        // stepped range, no hit: 1,5,9
        run_search(32'd1, 32'd10, 1'b0, 1'b0, edges, n1, n2);
        exp_n[0] = 32'd1; exp_n[1] = 32'd5; exp_n[2] = 32'd9;
        check("step_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < seen.size()) check("step_nonce", 64'(seen[i]), 64'(exp_n[i]));
        check("step_edges", 64'(edges), 64'd388);
        check("step_found", 64'(found), 64'd0);
        tick();

        // empty range
        run_search(32'd20, 32'd19, 1'b0, 1'b0, edges, n1, n2);
        check("empty_edges", 64'(edges), 64'd1);
        check("empty_en", 64'(n1 + n2), 64'd0);
        tick();

        // early stop at pass-2 round 60: 0,4,8 at 125 cycles each
        run_search(32'd0, 32'd8, 1'b0, 1'b1, edges, n1, n2);
        check("es_edges", 64'(edges), 64'd376);
        check("es_en2", 64'(n2), 64'd183);
        check("es_count", 64'(seen.size()), 64'd3);
        tick();

        // top of nonce space: F8, FC, then stop without wrapping
        run_search(32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0, 1'b0, edges, n1, n2);
        check("top_edges", 64'(edges), 64'd259);
        check("top_count", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) check("top_last", 64'(seen[1]), 64'hFFFF_FFFC);
        tick();

        // abort at pass-1 round 30, then reset during pass 2
        nonce_base = 32'd0; nonce_limit = 32'd100; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !(en1 && r_cntr == 6'd30); i++) tick();
        check("abort_reached", 64'({en1, r_cntr}), 64'({1'b1, 6'd30}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ctl", 64'({busy, en1, en2, done, r_cntr}), 64'd0);
        seen_done = 1'b0;
        repeat (5) begin tick(); if (done) seen_done = 1'b1; end
        check("abort_no_done", 64'(seen_done), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !(en2 && r_cntr == 6'd10); i++) tick();
        check("rst_reached", 64'(en2), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_ctl", 64'({busy, en1, en2, first_rnd, done, found, r_cntr}), 64'd0);
        check("rst_nonce", 64'({nonce, found_nonce}), 64'd0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (5) begin tick(); if (done || busy) seen_done = 1'b1; end
        check("rst_quiet", 64'(seen_done), 64'd0);

        // randomized run, checked by the model every cycle
        for (int c = 0; c < 15000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom % 5000 == 0) rst_n = 1'b0;
            case ($urandom % 10)
                0: begin
                    nonce_base = $urandom_range(1, 1000);
                    nonce_limit = nonce_base - 32'd1;
                end
                1: begin
                    nonce_base = 32'hFFFF_FFF0 + ($urandom % 16);
                    nonce_limit = 32'hFFFF_FFFF;
                end
                default: begin
                    nonce_base = $urandom_range(0, 1000);
                    nonce_limit = nonce_base + $urandom_range(0, 12);
                end
            endcase
            start = ($urandom % 6 == 0);
            hit = ($urandom % 3 == 0);
            early_stop = ($urandom % 80 == 0);
            abort = ($urandom % 1500 == 0);
            tick();
        end
        start = 1'b0; abort = 1'b0; hit = 1'b0; early_stop = 1'b0; rst_n = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
